ram_sync_ctrl: RTL and testbench
================================

// Module: ram_sync_ctrl
// PURPOSE
//  Parametrised synchronous RAM with a registered REQ/ACK access port and programmable wait states.
//  Successor to the 8-bit asynchronous chip-select RAM: generalised in data width, address width and depth.
//  Adds out-of-range detection and an optional clear-on-reset sweep.
//  Sits between the CPU bus sequencer and on-chip storage; one access in flight at a time.
// PARAMETERS
//  DATA_W       8            data word width (bits)
//  ADDR_W       8            address width (bits)
//  DEPTH        256          number of words implemented; legal range 1..2**ADDR_W
//  WAIT_STATES  2            extra cycles inserted before each access completes; legal range 0..15
// PORTS
//  CLK      in   1       clock; all state changes on rising edge
//  RST_BAR  in   1       asynchronous active-low reset
//  REQ      in   1       access request; sampled only in IDLE
//  WE_BAR   in   1       0 = write, 1 = read; sampled with REQ
//  A        in   ADDR_W  word address; sampled with REQ
//  D        in   DATA_W  write data; sampled with REQ
//  Q        out  DATA_W  read data; registered
//  ACK      out  1       one-cycle completion pulse
//  ERR      out  1       out-of-range flag; valid only while ACK=1
//  BUSY     out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (RST_BAR=0, immediate): state=IDLE, Q=0, ACK=0, ERR=0, BUSY=0, wait counter=0.
//  Reset effect on the array: contents untouched; a pending write is abandoned.
//  FSM states: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE, REQ=1 at edge E0:
//    - latch A, D and WE_BAR
//    - cnt <= WAIT_STATES; state <= ACCESS
//    - later changes on A, D or WE_BAR have no effect on this access
//  ACCESS, cnt != 0: cnt <= cnt-1.
//  ACCESS, cnt == 0 (edge E0+WAIT_STATES+1):
//    - write: mem[A] <= D; Q unchanged
//    - read: Q <= mem[A]
//    - ACK <= 1; state <= DONE
//  DONE: ACK <= 0, ERR <= 0; state <= IDLE.
//  Latency: ACK is high for exactly the one cycle after edge E0+WAIT_STATES+1.
//  Throughput: next request is accepted no earlier than edge E0+WAIT_STATES+3.
//  REQ while BUSY: ignored, not queued. The requester holds or re-raises REQ.
//  Out-of-range latched address (A >= DEPTH):
//    - same timing as a normal access
//    - no array write; Q unchanged
//    - ERR=1 together with ACK
//    - no aliasing onto in-range words
//  Read of a never-written word: Q takes the array content (X in simulation).
//  Address arithmetic: unsigned compare of ADDR_W-bit A against DEPTH. No wrap-around.
// CONFIGURATION
//  Macro RAM_CLEAR_EN defined:
//    - reset enters state CLEAR instead of IDLE; BUSY=1 during reset and throughout CLEAR
//    - CLEAR writes 0 to addresses 0..DEPTH-1, one word per cycle, then enters IDLE
//    - BUSY drops after exactly DEPTH edges following reset release
//    - REQ ignored during CLEAR; no ACK produced
//    - reset asserted mid-sweep restarts the sweep from address 0
//  Macro RAM_CLEAR_EN undefined:
//    - no CLEAR state; reset goes straight to IDLE with BUSY=0
//    - array is never cleared
// TESTING
//  1. WAIT_STATES=2. Write 8'hA5 to 8'h10 at E0.
//     -> BUSY=1 for 4 cycles; ACK pulses 1 cycle after edge E0+3.
//     Then read 8'h10 -> Q=8'hA5 when ACK=1, ERR=0.
//  2. WAIT_STATES=0. REQ held at 1 for 30 cycles, alternating writes/reads.
//     -> one ACK every 3 cycles (10 total); REQ during BUSY never produces an extra ACK.
//  3. DEPTH=200. Read 8'hC8 after Q=8'h11.
//     -> ACK with ERR=1; Q stays 8'h11.
//     Write 8'hFF to 8'd250 -> ERR=1; mem[8'd50] is unchanged.
//  4. mem[8'h20]=8'h07. Start write 8'h3C to 8'h20; pulse RST_BAR low during ACCESS.
//     -> no ACK; Q=0, BUSY=0 immediately.
//     Subsequent read of 8'h20 -> 8'h07.
//  5. Change A and D on the cycle after E0 of a write to 8'h05 with D=8'h5A.
//     -> read 8'h05 returns 8'h5A; the new address is unchanged.
//  6. RAM_CLEAR_EN defined, DEPTH=256.
//     -> after reset release BUSY=1 for exactly 256 cycles; REQ in that window gets no ACK.
//     Then read 8'hFF -> Q=8'h00.

Source files
------------

// File: rtl/ram_sync_ctrl.sv
// Synchronous RAM behind a registered REQ/ACK port with programmable wait states.
// Optional zero-fill sweep after reset when RAM_CLEAR_EN is defined.
module ram_sync_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk_i,
    input  logic              rst_bar_i,
    input  logic              req_i,
    input  logic              we_bar_i,
    input  logic [ADDR_W-1:0] a_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o
);

`ifdef RAM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_CLEAR} state_t;
    localparam state_t S_RESET = S_CLEAR;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    localparam state_t S_RESET = S_IDLE;
`endif

    localparam logic [3:0]      WS_C    = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic              we_bar_q;

    logic              accept;
    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

`ifdef RAM_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] clr_q, clr_d;
`endif

    assign accept   = (state_q == S_IDLE) && req_i;
    // Compare one bit wider so DEPTH == 2**ADDR_W is representable.
    assign in_range = ({1'b0, a_q} < DEPTH_C);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        ack_d     = ack_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = a_q;
        mem_wdata = d_q;
`ifdef RAM_CLEAR_EN
        clr_d     = clr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    cnt_d   = WS_C;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ack_d   = 1'b1;
                    err_d   = !in_range;
                    state_d = S_DONE;
                    if (in_range) begin
                        if (!we_bar_q) mem_we = 1'b1;
                        else           q_d    = mem[a_q];
                    end
                end
            end
            S_DONE: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
`ifdef RAM_CLEAR_EN
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_q;
                mem_wdata = '0;
                clr_d     = clr_q + 1'b1;
                if (clr_q == LAST_C) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_bar_i) begin
        if (!rst_bar_i) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            q_q     <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef RAM_CLEAR_EN
            clr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
`ifdef RAM_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end

    // Request fields are captured once at acceptance; later input changes are ignored.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            a_q      <= a_i;
            d_q      <= d_i;
            we_bar_q <= we_bar_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign q_o    = q_q;
    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_sync_ctrl.sv
// Scoreboard bench for ram_sync_ctrl: a driver pushes expected responses, a monitor
// pops and compares on every ACK. Covers both builds (RAM_CLEAR_EN defined or not).
module tb_ram_sync_ctrl;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int DEP = 200;
    localparam int WS  = 2;
    localparam int P   = WS + 3;

    logic          clk = 1'b0;
    logic          rst_bar;
    logic          req;
    logic          we_bar;
    logic [AW-1:0] a_in;
    logic [DW-1:0] d_in;
    logic [DW-1:0] q;
    logic          ack;
    logic          err;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    typedef struct {
        logic          err;
        logic [DW-1:0] q;
        bit            chk_q;
    } exp_t;
    exp_t sbq[$];

    logic [DW-1:0] mmem [256];
    bit            mknown [256];
    logic [DW-1:0] mq;
    bit            mq_known;

    ram_sync_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_STATES(WS)) dut (
        .clk_i(clk), .rst_bar_i(rst_bar), .req_i(req), .we_bar_i(we_bar),
        .a_i(a_in), .d_i(d_in), .q_o(q), .ack_o(ack), .err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: Q resets to 0; with the clear sweep the whole array reads back 0.
    task automatic model_reset();
        mq       = '0;
        mq_known = 1'b1;
`ifdef RAM_CLEAR_EN
        for (int i = 0; i < DEP; i++) begin
            mmem[i]   = '0;
            mknown[i] = 1'b1;
        end
`endif
    endtask

    task automatic model_issue(input logic wb, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        if (int'(a) >= DEP) begin
            e.err = 1'b1;
        end else begin
            e.err = 1'b0;
            if (!wb) begin
                mmem[a]   = d;
                mknown[a] = 1'b1;
            end else begin
                mq       = mmem[a];
                mq_known = mknown[a];
            end
        end
        e.q     = mq;
        e.chk_q = mq_known;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_bar === 1'b1 && ack === 1'b1) begin
            exp_t e;
            ack_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("ack_err", 32'(err), 32'(e.err));
                if (e.chk_q) chk("ack_q", 32'(q), 32'(e.q));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_access(input logic wb, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [AW-1:0] post_a, input logic [DW-1:0] post_d);
        int n;
        wait_idle();
        req = 1'b1; we_bar = wb; a_in = a; d_in = d;
        @(posedge clk);
        #1;
        model_issue(wb, a, d);
        req = 1'b0; we_bar = ~wb; a_in = post_a; d_in = post_d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n <= WS + 1) chk("busy_during", 32'(busy), 32'd1);
        end while (ack !== 1'b1 && n < 40);
        chk("ack_latency", 32'(n), 32'(WS + 2));
        @(negedge clk);
        chk("ack_pulse", 32'(ack), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic apply_reset_release();
        int n = 0;
        @(negedge clk);
        rst_bar = 1'b1;
`ifdef RAM_CLEAR_EN
        req = 1'b1; we_bar = 1'b1; a_in = 8'h10;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        chk("clear_busy_len", 32'(n), 32'(DEP));
`else
        chk("busy_after_rst", 32'(busy), 32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mmem[i]   = '0;
            mknown[i] = 1'b0;
        end
        rst_bar = 1'b0; req = 1'b0; we_bar = 1'b1; a_in = '0; d_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
`ifdef RAM_CLEAR_EN
        chk("rst_busy", 32'(busy), 32'd1);
`else
        chk("rst_busy", 32'(busy), 32'd0);
`endif
        apply_reset_release();

        // Basic write/read
        do_access(1'b0, 8'h10, 8'hA5, 8'h11, 8'h00);
        do_access(1'b1, 8'h10, 8'h00, 8'h12, 8'h34);
        chk("rd_a5", 32'(q), 32'hA5);

        // Range boundaries: 199 is last legal word, 200 and 250 are out of range
        do_access(1'b0, 8'd50, 8'h11, 8'd51, 8'h77);
        do_access(1'b0, 8'd199, 8'h9C, 8'd0, 8'h00);
        do_access(1'b1, 8'd50, 8'h00, 8'd0, 8'h00);
        do_access(1'b1, 8'hC8, 8'h00, 8'd50, 8'h00);
        chk("oor_q_hold", 32'(q), 32'h11);
        do_access(1'b0, 8'd250, 8'hFF, 8'd50, 8'hEE);
        do_access(1'b1, 8'd50, 8'h00, 8'd0, 8'h00);
        do_access(1'b1, 8'd199, 8'h00, 8'd0, 8'h00);

        // Inputs changing right after acceptance must not disturb the access
        do_access(1'b0, 8'h06, 8'h33, 8'h00, 8'h00);
        do_access(1'b0, 8'h05, 8'h5A, 8'h06, 8'hC3);
        do_access(1'b1, 8'h05, 8'h00, 8'h06, 8'h00);
        do_access(1'b1, 8'h06, 8'h00, 8'h05, 8'h00);

        // REQ held high: only one access per P cycles
        wait_idle();
        ack_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            logic          wb;
            logic [AW-1:0] ta;
            logic [DW-1:0] td;
            int            j;
            j  = k / P;
            td = DW'($urandom);
            if (k % P == 0) begin
                wb = j[0];
                ta = 8'h80 + AW'(j & ~1);
            end else begin
                wb = 1'($urandom);
                ta = AW'($urandom);
            end
            req = 1'b1; we_bar = wb; a_in = ta; d_in = td;
            @(posedge clk);
            #1;
            if (k % P == 0) model_issue(wb, ta, td);
            @(negedge clk);
        end
        req = 1'b0;
        repeat (8) @(negedge clk);
        chk("throughput_acks", 32'(ack_cnt), 32'(30 / P));

        // Reset in the middle of a write abandons it
        do_access(1'b0, 8'h20, 8'h07, 8'h00, 8'h00);
        wait_idle();
        req = 1'b1; we_bar = 1'b0; a_in = 8'h20; d_in = 8'h3C;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst_bar = 1'b0;
        #1;
        model_reset();
        chk("midrst_q", 32'(q), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
`ifdef RAM_CLEAR_EN
        chk("midrst_busy", 32'(busy), 32'd1);
`else
        chk("midrst_busy", 32'(busy), 32'd0);
`endif
        apply_reset_release();
        do_access(1'b1, 8'h20, 8'h00, 8'h00, 8'h00);
        do_access(1'b1, 8'd199, 8'h00, 8'h00, 8'h00);

        // Randomized traffic, biased onto a small address window
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] ra;
            if ($urandom_range(0, 3) == 0) ra = AW'($urandom_range(0, 255));
            else                           ra = 8'h60 + AW'($urandom_range(0, 7));
            do_access(1'($urandom), ra, DW'($urandom), AW'($urandom), DW'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
